// File: rtl/adc_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adc_stream_pkg                                            |
// | Brief    : Command opcodes, FSM state encoding and header default    |
// |            for the ADC capture streaming controller.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package adc_stream_pkg;

   // Host command opcodes, carried in rx_data[3:0]
   localparam logic [3:0] C_OP_START   = 4'h1;
   localparam logic [3:0] C_OP_STATUS  = 4'h2;
   localparam logic [3:0] C_OP_SET_DIV = 4'h4;
   localparam logic [3:0] C_OP_CONT    = 4'h5;
   localparam logic [3:0] C_OP_STOP    = 4'h6;

   // Default frame header byte
   localparam logic [7:0] C_HDR_DEFAULT = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_ARM   = 4'd1,
      ST_WAIT  = 4'd2,
      ST_HDR   = 4'd3,
      ST_LOAD  = 4'd4,
      ST_SEND  = 4'd5,
      ST_SENDW = 4'd6,
      ST_CKSUM = 4'd7,
      ST_STAT  = 4'd8,
      ST_END   = 4'd9
   } state_e;

endpackage
`default_nettype wire

// File: rtl/adc_stream_cmd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adc_stream_cmd                                            |
// | Brief    : Host command decoder. Holds the ADC divider, continuous   |
// |            mode and pending-stop flags; flags start/status requests  |
// |            that are only honoured while the streamer is idle.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module adc_stream_cmd
   import adc_stream_pkg::*;
#(
   parameter logic [3:0] DIV_INIT = 4'd3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_done_i,
   input  logic [7:0] rx_data_i,
   input  logic       idle_i,
   input  logic       end_clr_i,
   output logic [3:0] divider_o,
   output logic       cont_mode_o,
   output logic       stop_pending_o,
   output logic       start_req_o,
   output logic       status_req_o
);

   logic [3:0] divider_q, divider_d;
   logic       cont_q, cont_d;
   logic       stop_q, stop_d;
   logic [3:0] w_op;
   logic [3:0] w_arg;

   assign w_op  = rx_data_i[3:0];
   assign w_arg = rx_data_i[7:4];

   assign start_req_o    = rx_done_i && idle_i && ((w_op == C_OP_START) || (w_op == C_OP_CONT));
   assign status_req_o   = rx_done_i && idle_i && (w_op == C_OP_STATUS);
   assign divider_o      = divider_q;
   assign cont_mode_o    = cont_q;
   assign stop_pending_o = stop_q;

   // Command decode; a frame end that returns to idle clears both mode flags
   always_comb begin
      divider_d = divider_q;
      cont_d    = cont_q;
      stop_d    = stop_q;
      if (end_clr_i) begin
         cont_d = 1'b0;
         stop_d = 1'b0;
      end
      if (rx_done_i) begin
         case (w_op)
            C_OP_START: begin
               if (idle_i) begin
                  divider_d = w_arg;
                  cont_d    = 1'b0;
                  stop_d    = 1'b0;
               end
            end
            C_OP_CONT: begin
               if (idle_i) begin
                  divider_d = w_arg;
                  cont_d    = 1'b1;
                  stop_d    = 1'b0;
               end
            end
            C_OP_SET_DIV: divider_d = w_arg;
            C_OP_STOP: begin
               if (idle_i) begin
                  cont_d = 1'b0;
               end else if (!end_clr_i) begin
                  stop_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Decoder state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         divider_q <= DIV_INIT;
         cont_q    <= 1'b0;
         stop_q    <= 1'b0;
      end else begin
         divider_q <= divider_d;
         cont_q    <= cont_d;
         stop_q    <= stop_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/adc_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adc_stream_ctrl                                           |
// | Brief    : Streams a captured ADC frame from RAM to an FT245 FIFO:   |
// |            header byte, RAM words LSB byte first, optional checksum. |
// |            Define ADC_STREAM_CKSUM_EN to append the modulo-256       |
// |            checksum byte after the last data byte.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module adc_stream_ctrl
   import adc_stream_pkg::*;
#(
   parameter int         WORD_BYTES = 4,
   parameter int         ADDR_W     = 11,
   parameter int         LAST_ADDR  = 2047,
   parameter logic [7:0] HDR_BYTE   = C_HDR_DEFAULT,
   parameter logic [3:0] DIV_INIT   = 4'd3
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    rx_done,
   input  logic [7:0]              rx_data,
   input  logic                    tx_valid,
   input  logic                    tx_done,
   output logic                    tx_en,
   output logic [7:0]              tx_data,
   output logic                    start_turn,
   input  logic                    turn_done,
   output logic [3:0]              divider,
   output logic [ADDR_W-1:0]       ram_rd_addr,
   input  logic [8*WORD_BYTES-1:0] ram_rd_data,
   output logic                    busy
);

   localparam logic [1:0]        C_LAST_IDX  = 2'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(LAST_ADDR);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        idx_q, idx_d;
   logic              sent_q, sent_d;
   logic              tx_en_q, tx_en_d;
   logic [7:0]        tx_data_q, tx_data_d;
`ifdef ADC_STREAM_CKSUM_EN
   logic [7:0]        cksum_q, cksum_d;
`endif

   logic       w_cont, w_stop, w_start_req, w_status_req, w_end_clr;
   logic [7:0] w_bytes [4];
   logic [7:0] w_cur_byte;

   // Split the RAM word into bytes; unused lanes read as zero
   for (genvar i = 0; i < 4; i++) begin : g_bytes
      if (i < WORD_BYTES) begin : g_used
         assign w_bytes[i] = ram_rd_data[i*8 +: 8];
      end else begin : g_unused
         assign w_bytes[i] = 8'h00;
      end
   end
   assign w_cur_byte = w_bytes[idx_q];

   assign w_end_clr   = (state_q == ST_END) && !(w_cont && !w_stop);
   assign busy        = (state_q != ST_IDLE);
   assign start_turn  = (state_q == ST_ARM);
   assign tx_en       = tx_en_q;
   assign tx_data     = tx_data_q;
   assign ram_rd_addr = addr_q;

   adc_stream_cmd #(
      .DIV_INIT (DIV_INIT)
   ) u_cmd (
      .clk_i          (CLK),
      .rst_i          (RST),
      .rx_done_i      (rx_done),
      .rx_data_i      (rx_data),
      .idle_i         (state_q == ST_IDLE),
      .end_clr_i      (w_end_clr),
      .divider_o      (divider),
      .cont_mode_o    (w_cont),
      .stop_pending_o (w_stop),
      .start_req_o    (w_start_req),
      .status_req_o   (w_status_req)
   );

   // Next-state logic; header/checksum/status bytes use sent_q to split request and completion
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      idx_d     = idx_q;
      sent_d    = sent_q;
      tx_en_d   = 1'b0;
      tx_data_d = tx_data_q;
`ifdef ADC_STREAM_CKSUM_EN
      cksum_d   = cksum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_start_req)       state_d = ST_ARM;
            else if (w_status_req) state_d = ST_STAT;
         end
         ST_ARM: state_d = ST_WAIT;
         ST_WAIT: begin
            if (turn_done) begin
               addr_d  = '0;
               idx_d   = 2'd0;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
`ifdef ADC_STREAM_CKSUM_EN
            cksum_d = 8'h00;
`endif
            if (!sent_q) begin
               if (!tx_valid) begin
                  tx_en_d   = 1'b1;
                  tx_data_d = HDR_BYTE;
                  sent_d    = 1'b1;
               end
            end else if (tx_done) begin
               sent_d  = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_SEND;
         ST_SEND: begin
            if (!tx_valid) begin
               tx_en_d   = 1'b1;
               tx_data_d = w_cur_byte;
`ifdef ADC_STREAM_CKSUM_EN
               cksum_d   = cksum_q + w_cur_byte;
`endif
               state_d   = ST_SENDW;
            end
         end
         ST_SENDW: begin
            if (tx_done) begin
               if (idx_q == C_LAST_IDX) begin
                  idx_d = 2'd0;
                  if (addr_q == C_LAST_ADDR) begin
`ifdef ADC_STREAM_CKSUM_EN
                     state_d = ST_CKSUM;
`else
                     state_d = ST_END;
`endif
                  end else begin
                     addr_d  = addr_q + ADDR_W'(1);
                     state_d = ST_LOAD;
                  end
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_SEND;
               end
            end
         end
`ifdef ADC_STREAM_CKSUM_EN
         ST_CKSUM: begin
            if (!sent_q) begin
               if (!tx_valid) begin
                  tx_en_d   = 1'b1;
                  tx_data_d = cksum_q;
                  sent_d    = 1'b1;
               end
            end else if (tx_done) begin
               sent_d  = 1'b0;
               state_d = ST_END;
            end
         end
`endif
         ST_STAT: begin
            if (!sent_q) begin
               if (!tx_valid) begin
                  tx_en_d   = 1'b1;
                  tx_data_d = {w_cont, w_stop, 2'b00, divider};
                  sent_d    = 1'b1;
               end
            end else if (tx_done) begin
               sent_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_END: begin
            if (w_cont && !w_stop) state_d = ST_ARM;
            else                   state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and transmit registers; reset aborts any frame in progress
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         idx_q     <= 2'd0;
         sent_q    <= 1'b0;
         tx_en_q   <= 1'b0;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         idx_q     <= idx_d;
         sent_q    <= sent_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
      end
   end

`ifdef ADC_STREAM_CKSUM_EN
   // Running checksum of the data bytes of the current frame
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) cksum_q <= 8'h00;
      else     cksum_q <= cksum_d;
   end
`endif

endmodule
`default_nettype wire

// File: doc/adc_stream_ctrl.md
ADC_STREAM_CTRL -- requirements
Module: adc_stream_ctrl

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, bytes sent per RAM word (1..4), LSB byte first.
REQ-002 SHALL have parameter ADDR_W, default 11, RAM read-address width.
REQ-003 SHALL have parameter LAST_ADDR, default 2047, final RAM address of a frame.
REQ-004 SHALL have parameter HDR_BYTE, default 8'hA5, frame header byte.
REQ-005 SHALL have parameter DIV_INIT, default 3, divider reset value.
REQ-006 SHALL have the following ports; one clock, reset asynchronous and active-high:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous active-high reset
rx_done  in  1  one-cycle pulse, rx_data valid
rx_data  in  8  received command byte
tx_valid  in  1  FT245 busy; no tx_en while high
tx_done  in  1  one-cycle pulse, byte accepted
tx_en  out  1  one-cycle transmit request
tx_data  out  8  byte to transmit, held until tx_done
start_turn  out  1  one-cycle capture start pulse
turn_done  in  1  one-cycle capture complete pulse
divider  out  4  ADC clock divider code
ram_rd_addr  out  ADDR_W  capture RAM read address
ram_rd_data  in  8*WORD_BYTES  RAM word, valid 1 cycle after address change
busy  out  1  high in any state except IDLE

Function
REQ-007 SHALL decode rx_data[3:0] on rx_done: 1 START single, 2 STATUS, 4 SET_DIV, 5 CONT, 6 STOP; others ignored, no state change.
REQ-008 SHALL load divider from rx_data[7:4] on START, CONT (IDLE only) and SET_DIV (any state, effective next capture).
REQ-009 SHALL implement FSM IDLE, ARM, WAIT, HDR, LOAD, SEND, SENDW, CKSUM, STAT, END.
REQ-010 START/CONT in IDLE: IDLE->ARM; START/CONT outside IDLE ignored.
REQ-011 ARM: start_turn high exactly one cycle, ->WAIT.
REQ-012 WAIT: on turn_done, ram_rd_addr=0, byte index=0, ->HDR.
REQ-013 HDR/SEND/CKSUM/STAT byte handshake: wait tx_valid low, drive tx_data and pulse tx_en one cycle, then wait tx_done before next byte.
REQ-014 HDR sends HDR_BYTE, ->LOAD; LOAD waits one cycle for ram_rd_data, ->SEND.
REQ-015 SEND emits byte[index] of ram_rd_data; after WORD_BYTES bytes: if addr==LAST_ADDR ->CKSUM, else addr+1 ->LOAD.
REQ-016 Checksum: 8-bit modulo-256 sum of every data byte of the frame (header excluded), cleared in HDR.
REQ-017 END: in CONT mode with no pending STOP ->ARM, else ->IDLE and clear CONT mode.
REQ-018 STOP sets stop_pending; current frame completes fully, then IDLE; STOP in IDLE clears CONT mode only.
REQ-019 STATUS in IDLE ->STAT, sends {cont_mode, stop_pending, 2'b0, divider}, ->IDLE; STATUS when not IDLE ignored.
REQ-020 rx_done coincident with state transition: command evaluated against the current (pre-edge) state.
REQ-021 ram_rd_addr SHALL never exceed LAST_ADDR; no wrap.

Reset
REQ-022 RST high: state IDLE, tx_en=0, tx_data=0, start_turn=0, divider=DIV_INIT, ram_rd_addr=0, busy=0, cont_mode=0, stop_pending=0, checksum=0.
REQ-023 RST mid-frame SHALL abort immediately; no further tx_en after release until a new command.

Configuration
REQ-024 With ADC_STREAM_CKSUM_EN defined, CKSUM state sends checksum byte after last data byte; without it, CKSUM state and accumulator absent, last data byte ->END.

Structure
REQ-025 Package adc_stream_pkg SHALL hold command opcodes, FSM state encoding and HDR default.
REQ-026 One sub-module adc_stream_cmd (command decoder: divider, cont_mode, stop_pending, start request) is natural; the FSM stays in the top.

Verification
REQ-027 Reset, rx 8'h31 -> start_turn one pulse, divider=3; turn_done -> A5 then 4*2048 data bytes in LSB-first order, then checksum.
REQ-028 tx_valid held high 20 cycles mid-frame -> no tx_en during hold, no byte lost or repeated.
REQ-029 rx 8'h25 (CONT) then 8'h06 after second start_turn -> exactly two full frames, then IDLE, busy=0.
REQ-030 rx 8'h02 in IDLE with divider=7 -> single byte 8'h07, state IDLE.
REQ-031 RST asserted at address 100 -> outputs reset values same cycle; rx 8'h31 afterwards -> frame restarts at address 0.
REQ-032 WORD_BYTES=2, LAST_ADDR=3, ram word = address -> bytes A5,00,00,01,00,02,00,03,00,checksum 8'h06.
